// File: rtl/trap_controller_pkg.sv
// Shared definitions for the SPARC V8 trap sequencer: trap type codes and
// sequencer state encoding.
package trap_controller_pkg;

    localparam logic [7:0] TT_INST_ACCESS  = 8'h01;
    localparam logic [7:0] TT_ILLEGAL_INST = 8'h02;
    localparam logic [7:0] TT_PRIV_INST    = 8'h03;
    localparam logic [7:0] TT_FP_DISABLED  = 8'h04;
    localparam logic [7:0] TT_WIN_OVF      = 8'h05;
    localparam logic [7:0] TT_WIN_UNF      = 8'h06;
    localparam logic [7:0] TT_MEM_ALIGN    = 8'h07;
    localparam logic [7:0] TT_FP_EXC       = 8'h08;
    localparam logic [7:0] TT_DATA_ACCESS  = 8'h09;
    localparam logic [7:0] TT_TAG_OVF      = 8'h0A;

    localparam logic [7:0] TT_INTR_BASE    = 8'h10;
    localparam logic [7:0] TT_TICC_BASE    = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY1 = 3'd1,
        ST_ENTRY2 = 3'd2,
        ST_ENTRY3 = 3'd3,
        ST_ERROR  = 3'd4
    } trap_state_t;

endpackage

// File: rtl/trap_controller_prio_enc.sv
// Combinational trap priority encoder: picks the highest-priority pending
// trap source in V8 order and reports whether it is synchronous.
module trap_prio_enc
    import trap_controller_pkg::*;
#(
    parameter int NUM_EXC = 10,
    parameter int TT_W    = 8
) (
    input  logic [NUM_EXC-1:0] exc_req,
    input  logic               ticc_req,
    input  logic [6:0]         ticc_num,
    input  logic [3:0]         irl,
    input  logic [3:0]         pil,
    input  logic               et,
    output logic               valid,
    output logic [TT_W-1:0]    tt,
    output logic               is_sync
);

    logic intr_ok;

    // Sources are applied lowest priority first so later assignments win.
    always_comb begin
        intr_ok = et && (irl != 4'd0) && ((irl == 4'hF) || (irl > pil));
        valid   = 1'b0;
        tt      = '0;
        is_sync = 1'b0;
        if (intr_ok) begin
            valid = 1'b1;
            tt    = TT_W'(TT_INTR_BASE) | TT_W'(irl);
        end
        if (ticc_req) begin
            valid   = 1'b1;
            is_sync = 1'b1;
            tt      = TT_W'(TT_TICC_BASE) | TT_W'(ticc_num);
        end
        for (int i = NUM_EXC - 1; i >= 3; i--) begin
            if (exc_req[i]) begin
                valid   = 1'b1;
                is_sync = 1'b1;
                tt      = TT_W'(i + 1);
            end
        end
        // Privileged instruction (bit 2) outranks illegal instruction (bit 1).
        if (exc_req[1]) begin
            valid   = 1'b1;
            is_sync = 1'b1;
            tt      = TT_W'(TT_ILLEGAL_INST);
        end
        if (exc_req[2]) begin
            valid   = 1'b1;
            is_sync = 1'b1;
            tt      = TT_W'(TT_PRIV_INST);
        end
        if (exc_req[0]) begin
            valid   = 1'b1;
            is_sync = 1'b1;
            tt      = TT_W'(TT_INST_ACCESS);
        end
    end

endmodule

// File: rtl/trap_controller.sv
// SPARC V8 trap entry sequencer: selects a trap in IDLE, then drives the
// TBR/PSR/CWP, PC-save and fetch-redirect strobes over three cycles.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int NUM_EXC = 10,
    parameter int TT_W    = 8
) (
    input  logic               Clk,
    input  logic               Clr,
    input  logic [NUM_EXC-1:0] exc_req,
    input  logic               ticc_req,
    input  logic [6:0]         ticc_num,
    input  logic [3:0]         irl,
    input  logic [3:0]         pil,
    input  logic               et,
    input  logic               s,
    output logic [TT_W-1:0]    tbr_tt,
    output logic               tbr_en,
    output logic               psr_trap_wr,
    output logic               cwp_dec,
    output logic               save_pc_wr,
    output logic               save_npc_wr,
    output logic               pc_load_tbr,
    output logic               trap_ack,
    output logic               busy,
    output logic               error_mode
);

    trap_state_t     state_q, state_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic tbr_en_q, tbr_en_d, psr_wr_q, psr_wr_d, cwp_dec_q, cwp_dec_d;
    logic ack_q, ack_d, save_pc_q, save_pc_d, save_npc_q, save_npc_d;
    logic pc_load_q, pc_load_d, busy_q, busy_d, err_q, err_d;

    logic            enc_valid;
    logic [TT_W-1:0] enc_tt;
    logic            enc_sync;

    trap_prio_enc #(.NUM_EXC(NUM_EXC), .TT_W(TT_W)) u_prio (
        .exc_req  (exc_req),
        .ticc_req (ticc_req),
        .ticc_num (ticc_num),
        .irl      (irl),
        .pil      (pil),
        .et       (et),
        .valid    (enc_valid),
        .tt       (enc_tt),
        .is_sync  (enc_sync)
    );

    // Outputs are registered from the next-state decode so each strobe is
    // high exactly while the FSM sits in the matching state.
    always_comb begin
        state_d    = state_q;
        tt_d       = tt_q;
        tbr_en_d   = 1'b0;
        psr_wr_d   = 1'b0;
        cwp_dec_d  = 1'b0;
        ack_d      = 1'b0;
        save_pc_d  = 1'b0;
        save_npc_d = 1'b0;
        pc_load_d  = 1'b0;
        busy_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    busy_d = 1'b1;
                    if (enc_sync && !et) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = ST_ENTRY1;
                        tt_d      = enc_tt;
                        tbr_en_d  = 1'b1;
                        psr_wr_d  = 1'b1;
                        cwp_dec_d = 1'b1;
                        ack_d     = 1'b1;
                    end
                end
            end
            ST_ENTRY1: begin
                state_d   = ST_ENTRY2;
                save_pc_d = 1'b1;
                busy_d    = 1'b1;
            end
            ST_ENTRY2: begin
                state_d    = ST_ENTRY3;
                save_npc_d = 1'b1;
                pc_load_d  = 1'b1;
                busy_d     = 1'b1;
            end
            ST_ENTRY3: state_d = ST_IDLE;
            ST_ERROR: begin
                busy_d = 1'b1;
                err_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q    <= ST_IDLE;
            tt_q       <= '0;
            tbr_en_q   <= 1'b0;
            psr_wr_q   <= 1'b0;
            cwp_dec_q  <= 1'b0;
            ack_q      <= 1'b0;
            save_pc_q  <= 1'b0;
            save_npc_q <= 1'b0;
            pc_load_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tt_q       <= tt_d;
            tbr_en_q   <= tbr_en_d;
            psr_wr_q   <= psr_wr_d;
            cwp_dec_q  <= cwp_dec_d;
            ack_q      <= ack_d;
            save_pc_q  <= save_pc_d;
            save_npc_q <= save_npc_d;
            pc_load_q  <= pc_load_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // PSR.S is consumed by the datapath on psr_trap_wr; the sequencer itself
    // does not need it.
    logic unused_s;
    assign unused_s = s;

    assign tbr_tt      = tt_q;
    assign tbr_en      = tbr_en_q;
    assign psr_trap_wr = psr_wr_q;
    assign cwp_dec     = cwp_dec_q;
    assign trap_ack    = ack_q;
    assign save_pc_wr  = save_pc_q;
    assign save_npc_wr = save_npc_q;
    assign pc_load_tbr = pc_load_q;
    assign error_mode  = err_q;
    // Stall goes up in the detecting cycle, before the FSM has moved.
    assign busy = busy_q | ((state_q == ST_IDLE) && enc_valid && !Clr);

endmodule
